// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard detection unit.
// Optional perf counters are enabled by HDU_PERF_CNT_EN.
package hazard_pkg;
    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} hdu_state_e;

    localparam logic [4:0] REG_ZERO         = 5'd0;
    localparam int         DEF_FLUSH_CYCLES = 1;
    localparam int         DEF_MEM_TIMEOUT  = 64;

    // Bits needed to hold values 0..n-1; never less than one bit.
    function automatic int hdu_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/hazard_detection_unit_if.sv
// Hazard controller bus: ID/EX/MEM status in, pipeline control out.
// Perf counter signals exist only with HDU_PERF_CNT_EN.
interface hazard_detection_unit_if
`ifdef HDU_PERF_CNT_EN
    #(parameter int CNT_W = 32)
`endif
    ;
    logic [4:0] rs1_ID;
    logic [4:0] rs2_ID;
    logic       NONE_RS1_ID;
    logic       NONE_RS2_ID;
    logic [4:0] EX_rd;
    logic       EX_mem_read;
    logic       WB_EX;
    logic       NONE_RD_EX;
    logic       branch_taken_EX;
    logic       mem_req_MEM;
    logic       mem_ack;
    logic       stall_pc_o;
    logic       stall_IF_ID_o;
    logic       bubble_ID_EX_o;
    logic       flush_IF_ID_o;
    logic       freeze_o;
    logic       err_mem_timeout_o;
`ifdef HDU_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_load_use_o;
    logic [CNT_W-1:0] cnt_flush_o;
    logic [CNT_W-1:0] cnt_freeze_o;
`endif

    modport slave (
        input  rs1_ID, rs2_ID, NONE_RS1_ID, NONE_RS2_ID, EX_rd, EX_mem_read,
               WB_EX, NONE_RD_EX, branch_taken_EX, mem_req_MEM, mem_ack,
`ifdef HDU_PERF_CNT_EN
        output cnt_load_use_o, cnt_flush_o, cnt_freeze_o,
`endif
        output stall_pc_o, stall_IF_ID_o, bubble_ID_EX_o, flush_IF_ID_o,
               freeze_o, err_mem_timeout_o
    );

    modport master (
        output rs1_ID, rs2_ID, NONE_RS1_ID, NONE_RS2_ID, EX_rd, EX_mem_read,
               WB_EX, NONE_RD_EX, branch_taken_EX, mem_req_MEM, mem_ack,
`ifdef HDU_PERF_CNT_EN
        input  cnt_load_use_o, cnt_flush_o, cnt_freeze_o,
`endif
        input  stall_pc_o, stall_IF_ID_o, bubble_ID_EX_o, flush_IF_ID_o,
               freeze_o, err_mem_timeout_o
    );
endinterface

// File: rtl/comparator_5bit.sv
// 5-bit equality comparator used for register-index matching.
module comparator_5bit (
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic       eq
);
    assign eq = (a == b);
endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use stall, memory freeze and branch flush control for the ID/EX boundary.
// HDU_PERF_CNT_EN adds cycle counters for load-use stalls, flushes and freezes.
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT
`ifdef HDU_PERF_CNT_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    hazard_detection_unit_if.slave  hz
);
    localparam int WAIT_W  = hdu_w(MEM_TIMEOUT + 1);
    localparam int FLUSH_W = hdu_w(FLUSH_CYCLES);

    hdu_state_e         state, state_n;
    logic [WAIT_W-1:0]  wait_cnt, wait_n;
    logic [FLUSH_W-1:0] flush_cnt, flush_n;
    logic               err, err_n;

    logic eq_rs1, eq_rs2, load_use, mem_busy, frozen;
    logic stall_pc, stall_ifid, bubble, flush, freeze;

    comparator_5bit u_cmp_rs1 (.a(hz.EX_rd), .b(hz.rs1_ID), .eq(eq_rs1));
    comparator_5bit u_cmp_rs2 (.a(hz.EX_rd), .b(hz.rs2_ID), .eq(eq_rs2));

    assign load_use = hz.EX_mem_read & hz.WB_EX & ~hz.NONE_RD_EX & (hz.EX_rd != REG_ZERO) &
                      ((eq_rs1 & ~hz.NONE_RS1_ID) | (eq_rs2 & ~hz.NONE_RS2_ID));
    assign mem_busy = hz.mem_req_MEM & ~hz.mem_ack;
    // Once waiting on memory, only the ack releases the pipeline.
    assign frozen   = mem_busy | ((state == MEM_WAIT) & ~hz.mem_ack);

    always_comb begin
        state_n    = state;
        wait_n     = wait_cnt;
        flush_n    = flush_cnt;
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        bubble     = 1'b0;
        flush      = 1'b0;
        freeze     = 1'b0;
        if (frozen) begin
            freeze = 1'b1;
            // A freeze during FLUSH stays in FLUSH with flush_cnt held.
            if (state != FLUSH) begin
                state_n = MEM_WAIT;
                wait_n  = (wait_cnt == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt : wait_cnt + WAIT_W'(1);
            end
        end else begin
            wait_n = '0;
            if (hz.branch_taken_EX) begin
                flush   = 1'b1;
                bubble  = 1'b1;
                flush_n = FLUSH_W'(FLUSH_CYCLES - 1);
                state_n = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            end else if (state == FLUSH) begin
                flush   = 1'b1;
                flush_n = flush_cnt - FLUSH_W'(1);
                state_n = (flush_cnt <= FLUSH_W'(1)) ? RUN : FLUSH;
            end else begin
                state_n = RUN;
                if (load_use) begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    bubble     = 1'b1;
                end
            end
        end
        err_n = err | (wait_n == WAIT_W'(MEM_TIMEOUT));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= RUN;
            wait_cnt  <= '0;
            flush_cnt <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_n;
            flush_cnt <= flush_n;
            err       <= err_n;
        end
    end

    // Gate with reset so every output drops the moment reset asserts.
    assign hz.stall_pc_o        = stall_pc & rst_ni;
    assign hz.stall_IF_ID_o     = stall_ifid & rst_ni;
    assign hz.bubble_ID_EX_o    = bubble & rst_ni;
    assign hz.flush_IF_ID_o     = flush & rst_ni;
    assign hz.freeze_o          = freeze & rst_ni;
    assign hz.err_mem_timeout_o = err;

`ifdef HDU_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_lu, cnt_fl, cnt_fz;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_lu <= '0;
            cnt_fl <= '0;
            cnt_fz <= '0;
        end else begin
            cnt_lu <= cnt_lu + CNT_W'(stall_pc);
            cnt_fl <= cnt_fl + CNT_W'(flush);
            cnt_fz <= cnt_fz + CNT_W'(freeze);
        end
    end

    assign hz.cnt_load_use_o = cnt_lu;
    assign hz.cnt_flush_o    = cnt_fl;
    assign hz.cnt_freeze_o   = cnt_fz;
`endif
endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: two configurations driven in lockstep
// against a cycle-level reference model of the hazard rules.
module tb_hazard_detection_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] rs1, rs2, ex_rd;
    logic n_rs1, n_rs2, ex_ld, wb_ex, n_rd, br, req, ack;

    hazard_detection_unit_if ia ();
    hazard_detection_unit_if ib ();

    assign ia.rs1_ID = rs1;          assign ib.rs1_ID = rs1;
    assign ia.rs2_ID = rs2;          assign ib.rs2_ID = rs2;
    assign ia.NONE_RS1_ID = n_rs1;   assign ib.NONE_RS1_ID = n_rs1;
    assign ia.NONE_RS2_ID = n_rs2;   assign ib.NONE_RS2_ID = n_rs2;
    assign ia.EX_rd = ex_rd;         assign ib.EX_rd = ex_rd;
    assign ia.EX_mem_read = ex_ld;   assign ib.EX_mem_read = ex_ld;
    assign ia.WB_EX = wb_ex;         assign ib.WB_EX = wb_ex;
    assign ia.NONE_RD_EX = n_rd;     assign ib.NONE_RD_EX = n_rd;
    assign ia.branch_taken_EX = br;  assign ib.branch_taken_EX = br;
    assign ia.mem_req_MEM = req;     assign ib.mem_req_MEM = req;
    assign ia.mem_ack = ack;         assign ib.mem_ack = ack;

    hazard_detection_unit #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(64)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .hz(ia.slave));
    hazard_detection_unit #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(10)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .hz(ib.slave));

    // Reference model: one entry per DUT configuration.
    int fc [2] = '{1, 2};
    int mt [2] = '{64, 10};
    bit waiting [2];
    int flush_left [2];
    int busy_run [2];
    bit err [2];

    int total = 0;
    int bad = 0;

    function automatic bit load_use_m();
        bit hit1, hit2;
        hit1 = (ex_rd == rs1) && !n_rs1;
        hit2 = (ex_rd == rs2) && !n_rs2;
        return ex_ld && wb_ex && !n_rd && (ex_rd != 5'd0) && (hit1 || hit2);
    endfunction

    // {stall_pc, stall_IF_ID, bubble, flush, freeze, err}
    function automatic logic [5:0] expect_m(int k);
        logic [5:0] e;
        bit busy;
        busy = req && !ack;
        e = '0;
        if (rst_n) begin
            if (busy || (waiting[k] && !ack)) e[1] = 1'b1;
            else if (br)                      e[4:2] = 3'b011;
            else if (flush_left[k] > 0)       e[2] = 1'b1;
            else if (load_use_m())            e[5:3] = 3'b111;
            e[0] = err[k];
        end
        return e;
    endfunction

    task automatic model_clock();
        bit busy;
        busy = req && !ack;
        for (int k = 0; k < 2; k++) begin
            if (busy || (waiting[k] && !ack)) begin
                if (flush_left[k] == 0) begin
                    waiting[k] = 1'b1;
                    if (busy_run[k] < mt[k]) busy_run[k]++;
                    if (busy_run[k] >= mt[k]) err[k] = 1'b1;
                end
            end else begin
                waiting[k] = 1'b0;
                busy_run[k] = 0;
                if (br) flush_left[k] = fc[k] - 1;
                else if (flush_left[k] > 0) flush_left[k]--;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            waiting[k] = 1'b0;
            flush_left[k] = 0;
            busy_run[k] = 0;
            err[k] = 1'b0;
        end
    endtask

    task automatic check(string tag);
        logic [5:0] obs, exp;
        for (int k = 0; k < 2; k++) begin
            exp = expect_m(k);
            if (k == 0)
                obs = {ia.stall_pc_o, ia.stall_IF_ID_o, ia.bubble_ID_EX_o,
                       ia.flush_IF_ID_o, ia.freeze_o, ia.err_mem_timeout_o};
            else
                obs = {ib.stall_pc_o, ib.stall_IF_ID_o, ib.bubble_ID_EX_o,
                       ib.flush_IF_ID_o, ib.freeze_o, ib.err_mem_timeout_o};
            total++;
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s dut%0d observed=%b expected=%b", tag, k, obs, exp);
            end
        end
    endtask

    // Inputs are set at a negedge; check mid-cycle, advance model, wait next negedge.
    task automatic cyc(string tag);
        #1;
        check(tag);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; ex_rd = 5'd0;
        n_rs1 = 1'b0; n_rs2 = 1'b0; ex_ld = 1'b0; wb_ex = 1'b0; n_rd = 1'b0;
        br = 1'b0; req = 1'b0; ack = 1'b0;
    endtask

    task automatic load_use_setup();
        idle();
        ex_ld = 1'b1; wb_ex = 1'b1; ex_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd7;
    endtask

    task automatic reset_pulse(string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check({tag, "_async"});
        @(negedge clk);
        check({tag, "_held"});
        rst_n = 1'b1;
        idle();
        cyc({tag, "_run"});
    endtask

    initial begin
        idle();
        model_reset();
        #1;
        check("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc("idle");

        load_use_setup();         cyc("lu_rs1");
        idle();                   cyc("lu_after");
        load_use_setup(); rs1 = 5'd9; rs2 = 5'd5; cyc("lu_rs2");
        load_use_setup(); ex_rd = 5'd0; rs1 = 5'd0; cyc("lu_rd0");
        load_use_setup(); n_rs1 = 1'b1; cyc("lu_none_rs1");
        load_use_setup(); wb_ex = 1'b0; cyc("lu_no_wb");
        load_use_setup(); n_rd = 1'b1; cyc("lu_none_rd");
        load_use_setup(); ex_ld = 1'b0; cyc("lu_not_load");

        load_use_setup(); br = 1'b1; cyc("br_lu");
        idle();                   cyc("br_flush2");
        idle();                   cyc("br_done");

        idle(); req = 1'b1;
        for (int i = 0; i < 5; i++) cyc("freeze5");
        ack = 1'b1;               cyc("freeze_ack");
        idle();                   cyc("freeze_run");

        req = 1'b1; br = 1'b1;    cyc("busy_br");
        ack = 1'b1;               cyc("release_br");
        idle();                   cyc("release_flush");

        idle(); req = 1'b1;
        for (int i = 0; i < 67; i++) cyc("timeout");
        ack = 1'b1;               cyc("timeout_ack");
        idle();
        for (int i = 0; i < 3; i++) cyc("err_sticky");

        req = 1'b1;
        cyc("mw_pre");
        cyc("mw_pre2");
        reset_pulse("rst_memwait");

        br = 1'b1;                cyc("fl_pre");
        idle(); req = 1'b1;       cyc("fl_freeze");
        idle();
        reset_pulse("rst_flush");

        for (int i = 0; i < 600; i++) begin
            rs1   = 5'($urandom_range(0, 3));
            rs2   = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3));
            n_rs1 = ($urandom_range(0, 5) == 0);
            n_rs2 = ($urandom_range(0, 5) == 0);
            n_rd  = ($urandom_range(0, 7) == 0);
            ex_ld = $urandom_range(0, 1) != 0;
            wb_ex = ($urandom_range(0, 4) != 0);
            br    = ($urandom_range(0, 7) == 0);
            req   = ($urandom_range(0, 3) == 0);
            ack   = $urandom_range(0, 1) != 0;
            cyc("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
